// File: rtl/mul_div_unit_pkg.sv
// Shared MDU opcode encoding and FSM state type for the EX-stage multiply/divide unit.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mdu_op_e;

  typedef enum logic {
    StIdle,
    StRun
  } mdu_state_e;

  localparam int unsigned CntW = 8;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; the result is computed at the start edge
// and committed after a fixed latency so Busy can stall later MDU instructions.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Src1,
  input  logic [31:0] Src2,
  input  logic [3:0]  MDUOP,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      pend_hi_q, pend_lo_q;
  logic             commit_q;
  logic             busy_q;

  logic               signed_op;
  logic signed [32:0] a_ext, b_ext;
  logic signed [63:0] prod;
  logic signed [32:0] quot, rem;
  logic               unused_div_msb;

  // 33-bit operands let one signed operator cover both signed and unsigned forms, and make
  // 0x80000000 / -1 yield +2^31 whose low word is the architectural 0x80000000.
  always_comb begin
    signed_op = (MDUOP == MDU_MULT) || (MDUOP == MDU_DIV);
    a_ext     = {signed_op & Src1[31], Src1};
    b_ext     = {signed_op & Src2[31], Src2};
    prod      = 64'(a_ext) * 64'(b_ext);
    quot      = '0;
    rem       = '0;
    if (b_ext != '0) begin
      quot = a_ext / b_ext;
      rem  = a_ext % b_ext;
    end
  end

  assign unused_div_msb = quot[32] ^ rem[32];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      commit_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (Start) begin
            case (MDUOP)
              MDU_MULT, MDU_MULTU: begin
                pend_hi_q <= prod[63:32];
                pend_lo_q <= prod[31:0];
                commit_q  <= 1'b1;
                cnt_q     <= CntW'(MULT_CYCLES);
                busy_q    <= 1'b1;
                state_q   <= StRun;
              end
              MDU_DIV, MDU_DIVU: begin
                pend_hi_q <= rem[31:0];
                pend_lo_q <= quot[31:0];
                commit_q  <= (Src2 != 32'd0);
                cnt_q     <= CntW'(DIV_CYCLES);
                busy_q    <= 1'b1;
                state_q   <= StRun;
              end
              MDU_MTHI: hi_q <= Src1;
              MDU_MTLO: lo_q <= Src1;
              default: ;
            endcase
          end
        end
        StRun: begin
          // Start is ignored here; the pipeline already stalls on Busy.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            if (commit_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO and latency, a monitor
// pops and compares whenever a result is presented.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Src1, Src2;
  logic [3:0]  MDUOP;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  mul_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .Src1 (Src1),
    .Src2 (Src2),
    .MDUOP(MDUOP),
    .Start(Start),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  // Architectural reference: HI/LO after the op plus the Busy length it should cause.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int                sa, sb;
    longint            p, q, r;
    longint unsigned   pu;
    exp_t              e;
    sa = a;
    sb = b;
    e.len = -1;
    case (op)
      4'd1: begin
        p = longint'(sa) * longint'(sb);
        hi_m = p[63:32]; lo_m = p[31:0]; e.len = 5; e.tag = "mult";
      end
      4'd2: begin
        pu = {32'd0, a} * {32'd0, b};
        hi_m = pu[63:32]; lo_m = pu[31:0]; e.len = 5; e.tag = "multu";
      end
      4'd3: begin
        if (b != 32'd0) begin
          q = longint'(sa) / longint'(sb);
          r = longint'(sa) % longint'(sb);
          lo_m = q[31:0]; hi_m = r[31:0];
        end
        e.len = 10; e.tag = "div";
      end
      4'd4: begin
        if (b != 32'd0) begin
          lo_m = a / b; hi_m = a % b;
        end
        e.len = 10; e.tag = "divu";
      end
      4'd5: begin hi_m = a; e.len = 0; e.tag = "mthi"; end
      4'd6: begin lo_m = a; e.len = 0; e.tag = "mtlo"; end
      default: ;
    endcase
    if (e.len >= 0) begin
      e.hi = hi_m;
      e.lo = lo_m;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && Busy; i++) begin
      @(posedge clk); #1;
    end
    if (Busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout: got Busy=1 expected Busy=0 within 40 cycles");
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    Start = 1'b1; MDUOP = op; Src1 = a; Src2 = b;
    model_op(op, a, b);
    @(posedge clk); #1;
    Start = 1'b0; MDUOP = 4'd0;
    wait_idle();
  endtask

  // Monitor: result presented when Busy falls, or one cycle after an idle mthi/mtlo.
  initial begin
    int   run_len;
    logic prev_busy;
    logic mt_due;
    exp_t e;
    run_len   = 0;
    prev_busy = 1'b0;
    mt_due    = 1'b0;
    forever begin
      @(negedge clk);
      if (mt_due || (prev_busy && !Busy)) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: got a result with no expectation queued");
        end else begin
          e = sb_q.pop_front();
          check32({e.tag, "_hi"}, HI, e.hi);
          check32({e.tag, "_lo"}, LO, e.lo);
          if (mt_due) check32({e.tag, "_busy"}, {31'd0, Busy}, 32'd0);
          else        check32({e.tag, "_len"}, run_len, e.len);
        end
        mt_due  = 1'b0;
        run_len = 0;
      end
      if (Busy) run_len++;
      if (Start && !Busy && !reset && (MDUOP == 4'd5 || MDUOP == 4'd6)) mt_due = 1'b1;
      prev_busy = Busy;
    end
  end

  initial begin
    exp_t        e;
    logic [3:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; Start = 1'b0; MDUOP = 4'd0; Src1 = '0; Src2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check32("rst_hi", HI, 32'd0);
    check32("rst_lo", LO, 32'd0);
    check32("rst_busy", {31'd0, Busy}, 32'd0);

    issue(4'd1, 32'hFFFFFFFD, 32'd5);
    check32("mult_hi_const", HI, 32'hFFFFFFFF);
    check32("mult_lo_const", LO, 32'hFFFFFFF1);
    issue(4'd2, 32'hFFFFFFFF, 32'd2);
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    check32("div_lo_const", LO, 32'hFFFFFFFD);
    check32("div_hi_const", HI, 32'hFFFFFFFF);
    issue(4'd4, 32'd7, 32'd3);
    issue(4'd4, 32'd7, 32'd0);
    check32("divz_lo_const", LO, 32'd2);
    check32("divz_hi_const", HI, 32'd1);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    check32("ovf_lo_const", LO, 32'h80000000);

    // Back-to-back mthi/mtlo.
    @(posedge clk); #1;
    Start = 1'b1; MDUOP = 4'd5; Src1 = 32'h12345678; model_op(4'd5, Src1, Src2);
    @(posedge clk); #1;
    check32("mthi_busy", {31'd0, Busy}, 32'd0);
    MDUOP = 4'd6; Src1 = 32'h9ABCDEF0; model_op(4'd6, Src1, Src2);
    @(posedge clk); #1;
    check32("mtlo_busy", {31'd0, Busy}, 32'd0);
    Start = 1'b0; MDUOP = 4'd0;

    // Second Start during RUN is ignored, for a mult and for an mthi.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      Start = 1'b1; MDUOP = 4'd1; Src1 = 32'd1000 + k; Src2 = 32'hFFFFFFFE;
      model_op(4'd1, Src1, Src2);
      @(posedge clk); #1;
      Start = 1'b0;
      @(posedge clk); #1;
      Start = 1'b1; MDUOP = (k == 0) ? 4'd2 : 4'd5; Src1 = 32'hDEADBEEF; Src2 = 32'd3;
      @(posedge clk); #1;
      Start = 1'b0; MDUOP = 4'd0;
      wait_idle();
    end

    // Reset on the third Busy cycle of mult 6x7 discards the result.
    @(posedge clk); #1;
    Start = 1'b1; MDUOP = 4'd1; Src1 = 32'd6; Src2 = 32'd7;
    hi_m = '0; lo_m = '0;
    e.hi = '0; e.lo = '0; e.len = 3; e.tag = "rst_mid";
    sb_q.push_back(e);
    @(posedge clk); #1;
    Start = 1'b0; MDUOP = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check32("rstmid_busy", {31'd0, Busy}, 32'd0);
    check32("rstmid_lo", LO, 32'd0);
    repeat (8) @(posedge clk);
    issue(4'd5, 32'hAAAA5555, 32'd0);

    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      if (n % 3 != 0) op = 4'($urandom_range(1, 6));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: a = 32'h80000000;
        default: ;
      endcase
      issue(op, a, b);
    end

    repeat (3) @(posedge clk);
    check32("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the p6 pipeline. It sits beside the combinational ALU and takes the same operand buses.
- It accepts mult/multu/div/divu and mthi/mtlo operations and owns the architectural HI/LO registers.
- It reports Busy so the hazard unit can stall any later MDU instruction, including mfhi/mflo, until the result is committed.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high after a multiply start.
- DIV_CYCLES, 10, number of cycles Busy stays high after a divide start.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Src1  input  32  operand rs (dividend / multiplicand / mthi-mtlo source).
- Src2  input  32  operand rt (divisor / multiplier).
- MDUOP  input  4  operation code; see Behaviour.
- Start  input  1  qualifies MDUOP for this cycle; driven high for exactly one cycle per EX-stage MDU instruction.
- Busy  output  1  registered; high while a mult/div is in flight.
- HI  output  32  current HI register.
- LO  output  32  current LO register.

Behaviour:
- MDUOP encoding:
  - 0 = none
  - 1 = mult
  - 2 = multu
  - 3 = div
  - 4 = divu
  - 5 = mthi
  - 6 = mtlo
  - 7 to 15 are treated as none.
- Reset: HI=0, LO=0, Busy=0, counter=0, pending result=0. Reset takes priority over every other input, including mid-operation: the in-flight result is discarded and nothing is committed.
- States are IDLE and RUN, with a counter cnt.
- IDLE, Start=1, MDUOP 1 or 2:
  - Compute the 64-bit product at this edge (signed for 1, unsigned for 2).
  - Latch it into a pending register.
  - Set cnt=MULT_CYCLES, Busy=1, go to RUN.
- IDLE, Start=1, MDUOP 3 or 4:
  - Latch pending LO=quotient, pending HI=remainder (signed for 3, unsigned for 4).
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Set cnt=DIV_CYCLES, Busy=1, go to RUN.
- Divide with Src2==0: Busy runs the full DIV_CYCLES, then HI/LO are left unchanged (no commit).
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, with no trap.
- IDLE, Start=1, MDUOP 5: HI<=Src1 at this edge; Busy stays 0. MDUOP 6: LO<=Src1 likewise.
- RUN:
  - cnt decrements each cycle.
  - On the edge where cnt==1: commit pending to HI/LO (unless the op was a divide by zero), Busy<=0, go to IDLE.
  - Net timing: Busy is high for exactly N cycles after the Start edge, and the new HI/LO are visible in the same cycle Busy first reads 0.
- Start=1 while in RUN (any MDUOP): ignored. The pipeline must stall on (Start|Busy); Busy is not combinationally derived from Start.
- Start=0: MDUOP is ignored.
- HI and LO outputs are direct register outputs with no bypass. mfhi/mflo read them in EX once Busy=0.

Decomposition:
- The MDUOP codes (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO) go in the shared opcode-define header, alongside the ALUOP codes, so the controller and this unit agree.
- No sub-module. The arithmetic uses the synthesis operators `*`, `/` and `%` inside one module; the cycle counts model latency only.

Test Plan:
- mult, Src1=0xFFFFFFFD (-3), Src2=5, Start pulse -> Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu, Src1=0xFFFFFFFF, Src2=2 -> after 5 Busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
- div, Src1=0xFFFFFFF9 (-7), Src2=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 7 and 3 -> LO=2, HI=1. Then divu, Src1=7, Src2=0 -> Busy for 10 cycles; HI/LO still 1/2.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 on the next cycle -> HI and LO update the following edge, Busy never rises. A mult started during RUN with a second Start -> the second Start is ignored and the result is that of the first op.
- Start mult 6×7, assert reset on cycle 3 of Busy -> next cycle Busy=0, HI=0, LO=0, and no later commit of 42.
